// File: rtl/cgra_obi_col_arbiter.sv
// -----------------------------------------------------------------------------
// cgra_obi_col_arbiter
//
// Shares a single OBI master port between N_REQ per-column CGRA load/store
// masters. Requests are arbitrated round-robin. Once a request is on the bus
// but not yet granted, the winner stays selected, so the address phase does
// not change under the slave. Responses are routed back in order through an
// ID FIFO that records which column issued each accepted transaction.
//
// Handshake summary (OBI):
//   address phase : a transfer is accepted in the cycle where
//                   bus_req_o & bus_gnt_i; that same cycle the winning
//                   column sees col_gnt_o[sel]=1. The column fields stay
//                   stable while req is high and gnt is low.
//   response phase: bus_rvalid_i=1 completes the oldest outstanding
//                   transaction (reads and writes alike); the owning column
//                   sees col_rvalid_o for one cycle. There is no
//                   back-pressure on responses.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   col_req_i         per-column request
//   col_addr_i        per-column address, column j at [j*ADDR_W +: ADDR_W]
//   col_we_i          per-column write enable
//   col_be_i          per-column byte enables, column j at [j*BE_W +: BE_W]
//   col_wdata_i       per-column write data, column j at [j*DATA_W +: DATA_W]
//   col_gnt_o         per-column grant (one-hot or zero)
//   col_rvalid_o      per-column response valid (one-hot or zero)
//   col_rdata_o       response data, broadcast to all columns
//   bus_req_o ..      shared bus address phase (req/addr/we/be/wdata)
//   bus_gnt_i         bus grant
//   bus_rvalid_i      bus response valid
//   bus_rdata_i       bus response data
//   outst_o           number of accepted, unanswered transactions
//   err_o             sticky: response seen with nothing outstanding
//
// While rst_i is high every output, including the combinational ones, is 0.
// -----------------------------------------------------------------------------
module cgra_obi_col_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    localparam int BE_W     = DATA_W / 8,
    localparam int IDX_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_OUTST) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         col_req_i,
    input  logic [N_REQ*ADDR_W-1:0]  col_addr_i,
    input  logic [N_REQ-1:0]         col_we_i,
    input  logic [N_REQ*BE_W-1:0]    col_be_i,
    input  logic [N_REQ*DATA_W-1:0]  col_wdata_i,
    output logic [N_REQ-1:0]         col_gnt_o,
    output logic [N_REQ-1:0]         col_rvalid_o,
    output logic [DATA_W-1:0]        col_rdata_o,
    output logic                     bus_req_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    output logic                     bus_we_o,
    output logic [BE_W-1:0]          bus_be_o,
    output logic [DATA_W-1:0]        bus_wdata_o,
    input  logic                     bus_gnt_i,
    input  logic                     bus_rvalid_i,
    input  logic [DATA_W-1:0]        bus_rdata_i,
    output logic [CNT_W-1:0]         outst_o,
    output logic                     err_o
);

    // FIFO pointer width; a single-entry FIFO still needs a 1-bit pointer.
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    // Arbitration lock: OPEN = free round-robin choice each cycle,
    // LOCKED = a request is on the bus without grant, sel_q is pinned.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    lock_e            lock_q, lock_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    // -------------------------------------------------------------------------
    // Combinational arbitration signals
    // -------------------------------------------------------------------------
    logic             active;     // low while reset is asserted
    logic [IDX_W-1:0] sel;        // column currently driving the bus
    logic [IDX_W-1:0] cand;       // round-robin search candidate
    logic             sel_req;    // the selected column is requesting
    logic             fifo_full;
    logic             req;
    logic             accept;
    logic             pop;
    logic             spurious;
    logic [IDX_W-1:0] head_id;

    assign active = ~rst_i;

    // Winner selection. When locked the previous winner is held no matter
    // what other columns do. Otherwise scan rr_ptr_q, rr_ptr_q+1, ... and take
    // the first requester; the loop walks the order backwards so the final
    // assignment is the highest-priority hit.
    always_comb begin
        sel     = rr_ptr_q;
        cand    = '0;
        sel_req = 1'b0;
        if (lock_q == ARB_LOCKED) begin
            sel     = sel_q;
            sel_req = col_req_i[sel_q];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
                if (col_req_i[cand]) begin
                    sel     = cand;
                    sel_req = 1'b1;
                end
            end
        end
    end

    assign fifo_full = (count_q == MAX_CNT);

    // A full ID FIFO suppresses the request entirely, so no grant can be
    // accepted and no lock is taken until a response frees a slot.
    assign req      = active & sel_req & ~fifo_full;
    assign accept   = req & bus_gnt_i;
    assign pop      = active & bus_rvalid_i & (count_q != '0);
    assign spurious = active & bus_rvalid_i & (count_q == '0);
    assign head_id  = fifo_mem[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Address-phase forwarding and per-column strobes
    // -------------------------------------------------------------------------
    always_comb begin
        bus_addr_o  = '0;
        bus_we_o    = 1'b0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        col_gnt_o   = '0;
        col_rvalid_o = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (active && sel_req && (sel == IDX_W'(j))) begin
                bus_addr_o  = col_addr_i[j*ADDR_W +: ADDR_W];
                bus_we_o    = col_we_i[j];
                bus_be_o    = col_be_i[j*BE_W +: BE_W];
                bus_wdata_o = col_wdata_i[j*DATA_W +: DATA_W];
            end
            col_gnt_o[j]    = accept & (sel == IDX_W'(j));
            col_rvalid_o[j] = pop & (head_id == IDX_W'(j));
        end
    end

    assign bus_req_o   = req;
    assign col_rdata_o = active ? bus_rdata_i : '0;
    assign outst_o     = count_q;
    assign err_o       = err_q;

    // -------------------------------------------------------------------------
    // Lock and round-robin next state
    // -------------------------------------------------------------------------
    always_comb begin
        lock_d   = lock_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            lock_d   = ARB_OPEN;
            rr_ptr_d = (sel == IDX_LAST) ? '0 : sel + 1'b1;
        end else if (req) begin
            // Request pending without grant: pin the winner.
            lock_d = ARB_LOCKED;
            sel_d  = sel;
        end else if ((lock_q == ARB_LOCKED) && !sel_req) begin
            // The locked column dropped its request; do not wait on it.
            lock_d = ARB_OPEN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q   <= ARB_OPEN;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // ID FIFO of outstanding transactions and sticky error
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
